// File: rtl/pwm_ramp_sequencer_pkg.sv
// Shared types and default sizes for the PWM ramp sequencer.
package pwm_seq_pkg;

  localparam int DEF_CNT_W  = 8;
  localparam int DEF_STEP_W = 16;
  localparam int DEF_HOLD_W = 16;
  localparam int DEF_STEP   = 195;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    HOLD      = 2'd2,
    RAMP_DOWN = 2'd3
  } seq_state_e;

endpackage

// File: rtl/pwm_ramp_sequencer_if.sv
// Configuration handshake, start/abort commands and status of the sequencer.
// master = control/CSR side, slave = sequencer.
interface pwm_ramp_sequencer_if
  import pwm_seq_pkg::*;
#(
  parameter int CNT_W  = DEF_CNT_W,
  parameter int STEP_W = DEF_STEP_W,
  parameter int HOLD_W = DEF_HOLD_W
);
  logic              cfg_valid;
  logic              cfg_ready;
  logic [STEP_W-1:0] cfg_step;
  logic [CNT_W-1:0]  cfg_peak;
  logic [HOLD_W-1:0] cfg_hold;
  logic              start;
  logic              abort;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  duty;

  modport master (
    output cfg_valid, cfg_step, cfg_peak, cfg_hold, start, abort,
    input  cfg_ready, busy, done, duty
  );

  modport slave (
    input  cfg_valid, cfg_step, cfg_peak, cfg_hold, start, abort,
    output cfg_ready, busy, done, duty
  );
endinterface

// File: rtl/pwm_ramp_sequencer_compare.sv
// Free-running PWM counter with a registered compare against duty.
// pwm_o follows duty_i with one cycle of latency.
module pwm_compare #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] duty_i,
  output logic             pwm_o
);
  logic [CNT_W-1:0] cnt_q;
  logic             pwm_q;

  // Counter wraps naturally at all-ones; output high while counter is below duty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      pwm_q <= 1'b0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
      pwm_q <= (cnt_q < duty_i);
    end
  end

  assign pwm_o = pwm_q;
endmodule

// File: rtl/pwm_ramp_sequencer.sv
// Trapezoid duty profile sequencer: ramp up to peak, hold, ramp down, stop.
// Optional build macro PWM_SEQ_LOOP_EN: repeat the profile until abort.
module pwm_ramp_sequencer
  import pwm_seq_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int STEP_W   = DEF_STEP_W,
  parameter int HOLD_W   = DEF_HOLD_W,
  parameter int DEF_STEP = pwm_seq_pkg::DEF_STEP
) (
  input  logic                      clk,
  input  logic                      rst,
  pwm_ramp_sequencer_if.slave       bus,
  output logic                      pwm_out_o
);
  seq_state_e        state_q, state_d;
  logic [CNT_W-1:0]  duty_q, duty_d;
  logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              done_q, done_d;
  logic [STEP_W-1:0] cfg_step_q, cfg_step_d;
  logic [CNT_W-1:0]  cfg_peak_q, cfg_peak_d;
  logic [HOLD_W-1:0] cfg_hold_q, cfg_hold_d;
  logic [STEP_W-1:0] step_max;
  logic              busy;
  logic              tick;

  // A step period of 0 behaves as 1, so the terminal count never underflows.
  assign step_max = (cfg_step_q == '0) ? '0 : cfg_step_q - STEP_W'(1);
  assign busy     = (state_q != IDLE);
  assign tick     = busy && (step_cnt_q == step_max);

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      duty_q     <= '0;
      step_cnt_q <= '0;
      hold_cnt_q <= '0;
      done_q     <= 1'b0;
      cfg_step_q <= STEP_W'(DEF_STEP);
      cfg_peak_q <= '1;
      cfg_hold_q <= '0;
    end else begin
      state_q    <= state_d;
      duty_q     <= duty_d;
      step_cnt_q <= step_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      done_q     <= done_d;
      cfg_step_q <= cfg_step_d;
      cfg_peak_q <= cfg_peak_d;
      cfg_hold_q <= cfg_hold_d;
    end
  end

  // Next-state logic: config/start in IDLE, abort first when running, then tick-driven steps.
  always_comb begin
    state_d    = state_q;
    duty_d     = duty_q;
    step_cnt_d = step_cnt_q;
    hold_cnt_d = hold_cnt_q;
    done_d     = 1'b0;
    cfg_step_d = cfg_step_q;
    cfg_peak_d = cfg_peak_q;
    cfg_hold_d = cfg_hold_q;

    if (state_q == IDLE) begin
      step_cnt_d = '0;
      if (bus.cfg_valid) begin
        cfg_step_d = bus.cfg_step;
        cfg_peak_d = bus.cfg_peak;
        cfg_hold_d = bus.cfg_hold;
      end
      if (bus.start && !bus.abort) begin
        state_d    = RAMP_UP;
        duty_d     = '0;
        hold_cnt_d = '0;
      end
    end else if (bus.abort) begin
      state_d    = IDLE;
      duty_d     = '0;
      step_cnt_d = '0;
      hold_cnt_d = '0;
    end else begin
      step_cnt_d = tick ? '0 : step_cnt_q + STEP_W'(1);
      if (tick) begin
        case (state_q)
          RAMP_UP: begin
            // Comparing with >= keeps duty bounded by peak.
            if (duty_q >= cfg_peak_q) begin
              state_d    = HOLD;
              hold_cnt_d = '0;
            end else begin
              duty_d = duty_q + CNT_W'(1);
            end
          end
          HOLD: begin
            if (hold_cnt_q == cfg_hold_q) state_d = RAMP_DOWN;
            else hold_cnt_d = hold_cnt_q + HOLD_W'(1);
          end
          RAMP_DOWN: begin
            if (duty_q == '0) begin
              done_d     = 1'b1;
              hold_cnt_d = '0;
`ifdef PWM_SEQ_LOOP_EN
              state_d    = RAMP_UP;
`else
              state_d    = IDLE;
`endif
            end else begin
              duty_d = duty_q - CNT_W'(1);
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  assign bus.busy      = busy;
  assign bus.cfg_ready = ~busy;
  assign bus.done      = done_q;
  assign bus.duty      = duty_q;

  pwm_compare #(.CNT_W(CNT_W)) u_compare (
    .clk    (clk),
    .rst    (rst),
    .duty_i (duty_q),
    .pwm_o  (pwm_out_o)
  );
endmodule

// File: tb/tb_pwm_ramp_sequencer.sv
// Directed testbench for pwm_ramp_sequencer. Inputs change and outputs are
// sampled right after the falling clock edge.
module tb_pwm_ramp_sequencer;
  logic clk = 1'b0;
  logic rst;
  logic pwm_out;
  int   n_cmp = 0;
  int   n_bad = 0;
`ifdef PWM_SEQ_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  pwm_ramp_sequencer_if bus ();

  pwm_ramp_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .pwm_out_o (pwm_out)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    bus.cfg_valid = 1'b0;
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
  endtask

  // Offer a configuration together with start; the run begins at the next edge.
  task automatic cfg_start(input int step, input int peak, input int hold);
    bus.cfg_valid = 1'b1;
    bus.cfg_step  = 16'(step);
    bus.cfg_peak  = 8'(peak);
    bus.cfg_hold  = 16'(hold);
    bus.start     = 1'b1;
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic do_abort();
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    bus.cfg_step = '0; bus.cfg_peak = '0; bus.cfg_hold = '0;
    repeat (2) @(negedge clk);
    n_cmp++; if ({bus.busy, bus.done, bus.duty, pwm_out} !== 11'd0) begin
      n_bad++; $display("FAIL reset_outputs: got %b want 0", {bus.busy, bus.done, bus.duty, pwm_out}); end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.cfg_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset_cfg_ready: got %b want 1", bus.cfg_ready); end
    // Default step period of 195: first duty increment lands on edge 195.
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 1; k <= 195; k++) begin
      @(negedge clk);
      if (k == 194) begin
        n_cmp++; if (bus.duty !== 8'd0) begin
          n_bad++; $display("FAIL default_step_pre: got %0d want 0", bus.duty); end
      end
    end
    n_cmp++; if (bus.duty !== 8'd1) begin
      n_bad++; $display("FAIL default_step_tick: got %0d want 1", bus.duty); end
    do_abort();
  endtask

  task automatic test_profile();
    logic [7:0] exp_duty [0:21];
    exp_duty = '{0,0,1,1,2,2,3,3,3,3,3,3,3,3,2,2,1,1,0,0,0,0};
    cfg_start(2, 3, 1);
    for (int k = 0; k < 22; k++) begin
      if (k > 0) @(negedge clk);
      n_cmp++; if (bus.duty !== exp_duty[k]) begin
        n_bad++; $display("FAIL profile_duty k=%0d: got %0d want %0d", k, bus.duty, exp_duty[k]); end
      n_cmp++; if (bus.done !== (k == 20)) begin
        n_bad++; $display("FAIL profile_done k=%0d: got %b want %b", k, bus.done, (k == 20)); end
      n_cmp++; if (bus.busy !== ((k < 20) || LOOP)) begin
        n_bad++; $display("FAIL profile_busy k=%0d: got %b want %b", k, bus.busy, ((k < 20) || LOOP)); end
    end
    do_abort();
  endtask

  task automatic test_zero_step();
    cfg_start(0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      n_cmp++; if ({bus.done, bus.duty} !== {(k == 3), 8'd0}) begin
        n_bad++; $display("FAIL zero_step k=%0d: done/duty got %b/%0d want %b/0", k, bus.done, bus.duty, (k == 3)); end
      n_cmp++; if (bus.busy !== ((k < 3) || LOOP)) begin
        n_bad++; $display("FAIL zero_step_busy k=%0d: got %b want %b", k, bus.busy, ((k < 3) || LOOP)); end
    end
    do_abort();
  endtask

  task automatic test_pwm_full();
    int highs = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (pwm_out) highs++;
    end
    n_cmp++; if (highs != 0) begin
      n_bad++; $display("FAIL pwm_duty0: got %0d highs want 0", highs); end
    cfg_start(1, 255, 599);
    repeat (300) @(negedge clk);
    highs = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (pwm_out) highs++;
    end
    n_cmp++; if (highs != 255) begin
      n_bad++; $display("FAIL pwm_duty255: got %0d highs want 255", highs); end
    do_abort();
  endtask

  // Hold at peak 64, count PWM highs, then reset asynchronously mid-HOLD.
  task automatic test_pwm_hold_async_reset();
    int highs = 0;
    int w = 0;
    cfg_start(100, 64, 100);
    while (bus.duty !== 8'd64 && w < 8000) begin @(negedge clk); w++; end
    n_cmp++; if (w >= 8000) begin
      n_bad++; $display("FAIL hold_reach_peak: got duty %0d want 64", bus.duty); end
    repeat (200) @(negedge clk);
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (pwm_out) highs++;
    end
    n_cmp++; if (highs != 64) begin
      n_bad++; $display("FAIL pwm_hold64: got %0d highs want 64", highs); end
    w = 0;
    while (pwm_out !== 1'b1 && w < 300) begin @(negedge clk); w++; end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if ({bus.busy, bus.done, bus.duty, pwm_out} !== 11'd0) begin
      n_bad++; $display("FAIL async_reset: got %b want 0", {bus.busy, bus.done, bus.duty, pwm_out}); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.cfg_ready !== 1'b1) begin
      n_bad++; $display("FAIL async_reset_ready: got %b want 1", bus.cfg_ready); end
  endtask

  task automatic test_abort();
    int w = 0;
    int dones = 0;
    cfg_start(3, 20, 0);
    while (bus.duty !== 8'd10 && w < 100) begin @(negedge clk); w++; end
    n_cmp++; if (w >= 100) begin
      n_bad++; $display("FAIL abort_reach10: got duty %0d want 10", bus.duty); end
    do_abort();
    n_cmp++; if ({bus.busy, bus.done, bus.duty, bus.cfg_ready} !== {10'd0, 1'b1}) begin
      n_bad++; $display("FAIL abort_state: got %b want 00000000001", {bus.busy, bus.done, bus.duty, bus.cfg_ready}); end
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    n_cmp++; if (dones != 0) begin
      n_bad++; $display("FAIL abort_no_done: got %0d pulses want 0", dones); end
  endtask

  // Config offer and start during a run are ignored; next run keeps the old peak.
  task automatic test_cfg_locked();
    int first_done = -1;
    int dones = 0;
    int max_duty = 0;
    cfg_start(2, 3, 0);
    for (int k = 0; k <= 40; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 3) begin
        bus.cfg_valid = 1'b1; bus.cfg_peak = 8'd5; bus.cfg_step = 16'd1; bus.start = 1'b1;
        #1;
        n_cmp++; if (bus.cfg_ready !== 1'b0) begin
          n_bad++; $display("FAIL locked_ready: got %b want 0", bus.cfg_ready); end
      end
      if (k == 5) idle_inputs();
      if (bus.done) begin dones++; if (first_done < 0) first_done = k; end
      if (int'(bus.duty) > max_duty) max_duty = int'(bus.duty);
      if (k == 19 || k == 37) begin
        n_cmp++; if (bus.busy !== LOOP) begin
          n_bad++; $display("FAIL locked_busy k=%0d: got %b want %b", k, bus.busy, LOOP); end
      end
    end
    n_cmp++; if (first_done != 18) begin
      n_bad++; $display("FAIL locked_done_edge: got %0d want 18", first_done); end
    n_cmp++; if (dones != (LOOP ? 2 : 1)) begin
      n_bad++; $display("FAIL locked_done_count: got %0d want %0d", dones, (LOOP ? 2 : 1)); end
    n_cmp++; if (max_duty != 3) begin
      n_bad++; $display("FAIL locked_peak: got %0d want 3", max_duty); end
    do_abort();
    if (!LOOP) begin
      first_done = -1; max_duty = 0;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      for (int k = 0; k < 22; k++) begin
        if (k > 0) @(negedge clk);
        if (bus.done && first_done < 0) first_done = k;
        if (int'(bus.duty) > max_duty) max_duty = int'(bus.duty);
      end
      n_cmp++; if (max_duty != 3 || first_done != 18) begin
        n_bad++; $display("FAIL rerun_old_cfg: got peak %0d done %0d want peak 3 done 18", max_duty, first_done); end
    end
  endtask

  initial begin
    test_reset();
    test_profile();
    test_zero_step();
    test_pwm_full();
    test_pwm_hold_async_reset();
    test_abort();
    test_cfg_locked();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
